// File: rtl/fb_seq_pkg.sv
// Shared types and default geometry for the framebuffer write sequencer.
package fb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCENE   = 2'd1,
        OVERLAY = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int XW_DEF    = 10;
    localparam int YW_DEF    = 10;
    localparam int CW_DEF    = 4;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

endpackage

// File: rtl/fb_seq_watchdog.sv
// Phase watchdog: counts idle cycles while enabled and flags expiry on the TIMEOUT-th one.
module fb_seq_watchdog #(
    parameter int TIMEOUT = 800000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] cnt;

    // Independent of clear so the caller may derive clear from the phase change expiry causes.
    assign expired = enable && (cnt == CNTW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || !enable || expired)
            cnt <= '0;
        else
            cnt <= cnt + CNTW'(1);
    end

endmodule

// File: rtl/fb_write_sequencer.sv
// Arbitrates the single VGA pixel-write port: scene pixels, then overlay pixels, each frame.
// Define FB_WR_STATS_EN to add the pix_count / overrun_count statistics outputs.
module fb_write_sequencer
    import fb_seq_pkg::*;
#(
    parameter int XW      = XW_DEF,
    parameter int YW      = YW_DEF,
    parameter int CW      = CW_DEF,
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int TIMEOUT = 800000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_update,
    input  logic          overlay_en,
    input  logic          s0_valid,
    input  logic [XW-1:0] s0_x,
    input  logic [YW-1:0] s0_y,
    input  logic [CW-1:0] s0_colour,
    input  logic          s0_last,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [XW-1:0] s1_x,
    input  logic [YW-1:0] s1_y,
    input  logic [CW-1:0] s1_colour,
    input  logic          s1_last,
    output logic          s1_ready,
    output logic          m_valid,
    output logic [XW-1:0] m_x,
    output logic [YW-1:0] m_y,
    output logic [CW-1:0] m_colour,
    output logic          frame_done,
    output logic          busy
`ifdef FB_WR_STATS_EN
    ,
    output logic [19:0]   pix_count,
    output logic [7:0]    overrun_count
`endif
);

    state_t        state, next;
    logic          accept, last_beat, fwd, expired, timeout_fire, wd_clear;
    logic [XW-1:0] beat_x;
    logic [YW-1:0] beat_y;
    logic [CW-1:0] beat_colour;

    assign s0_ready   = (state == SCENE);
    assign s1_ready   = (state == OVERLAY);
    assign busy       = s0_ready || s1_ready;
    assign frame_done = (state == DONE);

    always_comb begin
        accept      = 1'b0;
        last_beat   = 1'b0;
        beat_x      = s0_x;
        beat_y      = s0_y;
        beat_colour = s0_colour;
        if (state == SCENE) begin
            accept    = s0_valid;
            last_beat = s0_last;
        end else if (state == OVERLAY) begin
            accept      = s1_valid;
            last_beat   = s1_last;
            beat_x      = s1_x;
            beat_y      = s1_y;
            beat_colour = s1_colour;
        end
    end

    // An accepted beat in the expiry cycle counts as progress, so it wins over the timeout.
    assign timeout_fire = expired && !accept;
    assign fwd = accept && (int'(beat_x) < H_RES) && (int'(beat_y) < V_RES);

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (frame_update) next = SCENE;
            SCENE:   if ((accept && last_beat) || timeout_fire)
                         next = overlay_en ? OVERLAY : DONE;
            OVERLAY: if ((accept && last_beat) || timeout_fire) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
        if (frame_update) next = SCENE;
    end

    assign wd_clear = accept || frame_update || (next != state);

    fb_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_x      <= '0;
            m_y      <= '0;
            m_colour <= '0;
        end else begin
            m_valid <= fwd;
            if (fwd) begin
                m_x      <= beat_x;
                m_y      <= beat_y;
                m_colour <= beat_colour;
            end
        end
    end

`ifdef FB_WR_STATS_EN
    logic [19:0] frame_pix;
    logic [1:0]  overrun_inc;
    logic [8:0]  overrun_sum;

    always_comb begin
        overrun_inc = 2'(frame_update && (state != IDLE)) + 2'(timeout_fire);
        overrun_sum = {1'b0, overrun_count} + 9'(overrun_inc);
    end

    // The final forwarded beat lands while in DONE, so it is folded in at the latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_pix     <= '0;
            pix_count     <= '0;
            overrun_count <= '0;
        end else begin
            if (state == DONE) pix_count <= frame_pix + 20'(m_valid);
            if (frame_update || state == DONE) frame_pix <= '0;
            else                               frame_pix <= frame_pix + 20'(m_valid);
            overrun_count <= overrun_sum[8] ? 8'hFF : overrun_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Randomised frame scenarios against a phase/scoreboard model, plus directed edge cases.
module tb_fb_write_sequencer;

    localparam int TO      = 16;
    localparam int P_IDLE  = 0;
    localparam int P_SCENE = 1;
    localparam int P_OVER  = 2;
    localparam int P_DONE  = 3;

    typedef struct {
        int x;
        int y;
        int c;
        bit last;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst, frame_update, overlay_en;
    logic       s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
    logic [9:0] s0_x, s0_y, s1_x, s1_y, m_x, m_y;
    logic [3:0] s0_colour, s1_colour, m_colour;
    logic       m_valid, frame_done, busy;
`ifdef FB_WR_STATS_EN
    logic [19:0] pix_count;
    logic [7:0]  overrun_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fb_write_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .frame_update(frame_update), .overlay_en(overlay_en),
        .s0_valid(s0_valid), .s0_x(s0_x), .s0_y(s0_y), .s0_colour(s0_colour),
        .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_x(s1_x), .s1_y(s1_y), .s1_colour(s1_colour),
        .s1_last(s1_last), .s1_ready(s1_ready),
        .m_valid(m_valid), .m_x(m_x), .m_y(m_y), .m_colour(m_colour),
        .frame_done(frame_done), .busy(busy)
`ifdef FB_WR_STATS_EN
        , .pix_count(pix_count), .overrun_count(overrun_count)
`endif
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        frame_update = 0; overlay_en = 1;
        s0_valid = 0; s0_x = 0; s0_y = 0; s0_colour = 0; s0_last = 0;
        s1_valid = 0; s1_x = 0; s1_y = 0; s1_colour = 0; s1_last = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        cyc();
    endtask

    function automatic bit on_screen(pix_t p);
        return (p.x < 640) && (p.y < 480);
    endfunction

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        n_checks += 8;
        if (s0_ready !== 0)   begin n_fail++; $display("FAIL reset_s0_ready: got %0b want 0", s0_ready); end
        if (s1_ready !== 0)   begin n_fail++; $display("FAIL reset_s1_ready: got %0b want 0", s1_ready); end
        if (m_valid !== 0)    begin n_fail++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
        if (m_x !== 0)        begin n_fail++; $display("FAIL reset_m_x: got %0d want 0", m_x); end
        if (m_y !== 0)        begin n_fail++; $display("FAIL reset_m_y: got %0d want 0", m_y); end
        if (m_colour !== 0)   begin n_fail++; $display("FAIL reset_m_colour: got %0d want 0", m_colour); end
        if (frame_done !== 0) begin n_fail++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        if (busy !== 0)       begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
`ifdef FB_WR_STATS_EN
        n_checks++;
        if (pix_count !== 0 || overrun_count !== 0) begin
            n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", pix_count, overrun_count);
        end
`endif
        @(posedge clk);
        #1;
        rst = 0;
        cyc();
    endtask

    // One whole frame from IDLE; s1 keeps its first beat presented while stalled.
    task automatic run_frame(input int n0, input int n1, input bit ov_en, input bit clip, input string tag);
        pix_t sc[$];
        pix_t ov[$];
        pix_t p, pend;
        bit   pend_v = 0, fin = 0, g;
        int   i0 = 0, i1 = 0, gap0 = 0, gap1 = 0, ph = P_IDLE, cycles = 0, exp_pix = 0;
        for (int k = 0; k < n0 + n1; k++) begin
            p.x = clip ? int'($urandom_range(700, 0)) : int'($urandom_range(639, 0));
            p.y = clip ? int'($urandom_range(520, 0)) : int'($urandom_range(479, 0));
            p.c = int'($urandom_range(15, 0));
            p.last = (k == n0 - 1) || (k == n0 + n1 - 1);
            if (k < n0) sc.push_back(p);
            else        ov.push_back(p);
            if (on_screen(p) && (k < n0 || ov_en)) exp_pix++;
        end
        while (!fin) begin
            frame_update = (cycles == 0);
            overlay_en   = ov_en;
            g = (ph == P_SCENE) && ($urandom_range(3, 0) == 0) && (gap0 < 4);
            gap0 = g ? gap0 + 1 : 0;
            s0_valid = (i0 < n0) && !g;
            if (i0 < n0) begin
                s0_x = 10'(sc[i0].x); s0_y = 10'(sc[i0].y); s0_colour = 4'(sc[i0].c); s0_last = sc[i0].last;
            end
            g = (ph == P_OVER) && ($urandom_range(3, 0) == 0) && (gap1 < 4);
            gap1 = g ? gap1 + 1 : 0;
            s1_valid = (i1 < n1) && !g;
            if (i1 < n1) begin
                s1_x = 10'(ov[i1].x); s1_y = 10'(ov[i1].y); s1_colour = 4'(ov[i1].c); s1_last = ov[i1].last;
            end
            @(negedge clk);
            n_checks += 5;
            if (s0_ready !== (ph == P_SCENE)) begin
                n_fail++; $display("FAIL %s_s0_ready cyc %0d: got %0b want %0b", tag, cycles, s0_ready, ph == P_SCENE);
            end
            if (s1_ready !== (ph == P_OVER)) begin
                n_fail++; $display("FAIL %s_s1_ready cyc %0d: got %0b want %0b", tag, cycles, s1_ready, ph == P_OVER);
            end
            if (busy !== (ph == P_SCENE || ph == P_OVER)) begin
                n_fail++; $display("FAIL %s_busy cyc %0d: got %0b", tag, cycles, busy);
            end
            if (frame_done !== (ph == P_DONE)) begin
                n_fail++; $display("FAIL %s_frame_done cyc %0d: got %0b want %0b", tag, cycles, frame_done, ph == P_DONE);
            end
            if (m_valid !== pend_v) begin
                n_fail++; $display("FAIL %s_m_valid cyc %0d: got %0b want %0b", tag, cycles, m_valid, pend_v);
            end
            if (pend_v) begin
                n_checks++;
                if (m_x !== 10'(pend.x) || m_y !== 10'(pend.y) || m_colour !== 4'(pend.c)) begin
                    n_fail++;
                    $display("FAIL %s_m_pixel cyc %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                             tag, cycles, m_x, m_y, m_colour, pend.x, pend.y, pend.c);
                end
            end
            if (ph == P_IDLE && cycles > 0) begin
`ifdef FB_WR_STATS_EN
                n_checks++;
                if (pix_count !== 20'(exp_pix)) begin
                    n_fail++; $display("FAIL %s_pix_count: got %0d want %0d", tag, pix_count, exp_pix);
                end
`endif
                fin = 1;
            end else begin
                @(posedge clk);
                pend_v = 0;
                case (ph)
                    P_IDLE:  ph = P_SCENE;
                    P_SCENE: if (s0_valid) begin
                                 pend = sc[i0]; pend_v = on_screen(pend);
                                 if (pend.last) ph = ov_en ? P_OVER : P_DONE;
                                 i0++;
                             end
                    P_OVER:  if (s1_valid) begin
                                 pend = ov[i1]; pend_v = on_screen(pend);
                                 if (pend.last) ph = P_DONE;
                                 i1++;
                             end
                    default: ph = P_IDLE;
                endcase
                #1;
                cycles++;
                if (cycles > 500) begin
                    n_checks++; n_fail++; fin = 1;
                    $display("FAIL %s_frame_timeout: got %0d cycles want < 500", tag, cycles);
                end
            end
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_basic;
        run_frame(3, 2, 1, 0, "basic");
    endtask

    task automatic test_no_overlay;
        run_frame(1, 2, 0, 0, "no_overlay");
    endtask

    task automatic test_random;
        for (int f = 0; f < 20; f++)
            run_frame(int'($urandom_range(6, 1)), int'($urandom_range(5, 1)), 1'($urandom_range(3, 0) != 0), 1, "random");
    endtask

    task automatic test_clip;
        do_reset();
        frame_update = 1;
        cyc();
        frame_update = 0;
        s0_valid = 1; s0_x = 640; s0_y = 10; s0_colour = 5; s0_last = 1;
        @(negedge clk);
        n_checks++;
        if (s0_ready !== 1) begin n_fail++; $display("FAIL clip_s0_ready: got %0b want 1", s0_ready); end
        @(posedge clk); #1;
        s0_valid = 0;
        @(negedge clk);
        n_checks += 2;
        if (m_valid !== 0)  begin n_fail++; $display("FAIL clip_m_valid: got %0b want 0", m_valid); end
        if (s1_ready !== 1) begin n_fail++; $display("FAIL clip_to_overlay: got %0b want 1", s1_ready); end
        @(posedge clk); #1;
        s1_valid = 1; s1_x = 639; s1_y = 479; s1_colour = 3; s1_last = 1;
        cyc();
        s1_valid = 0;
        @(negedge clk);
        n_checks += 2;
        if (m_valid !== 1 || m_x !== 10'd639 || m_y !== 10'd479) begin
            n_fail++; $display("FAIL clip_edge_pixel: got v%0b (%0d,%0d) want v1 (639,479)", m_valid, m_x, m_y);
        end
        if (frame_done !== 1) begin n_fail++; $display("FAIL clip_frame_done: got %0b want 1", frame_done); end
        cyc();
    endtask

    task automatic test_watchdog;
        int n;
        do_reset();
        frame_update = 1;
        cyc();
        frame_update = 0;
        @(negedge clk);
        n = 0;
        while (s0_ready === 1 && n < 100) begin n++; @(negedge clk); end
        n_checks += 2;
        if (n !== TO)       begin n_fail++; $display("FAIL wd_scene_cycles: got %0d want %0d", n, TO); end
        if (s1_ready !== 1) begin n_fail++; $display("FAIL wd_to_overlay: got %0b want 1", s1_ready); end
`ifdef FB_WR_STATS_EN
        n_checks++;
        if (overrun_count !== 8'd1) begin n_fail++; $display("FAIL wd_overrun: got %0d want 1", overrun_count); end
`endif
        n = 0;
        while (s1_ready === 1 && n < 100) begin n++; @(negedge clk); end
        n_checks += 2;
        if (n !== TO)         begin n_fail++; $display("FAIL wd_overlay_cycles: got %0d want %0d", n, TO); end
        if (frame_done !== 1) begin n_fail++; $display("FAIL wd_frame_done: got %0b want 1", frame_done); end
        cyc();
    endtask

    task automatic test_abort;
        int n;
        do_reset();
        frame_update = 1;
        cyc();
        frame_update = 0;
        s0_valid = 1; s0_last = 1; s0_x = 1; s0_y = 1;
        cyc();
        s0_valid = 0;
        for (int k = 0; k < 10; k++) cyc();
        frame_update = 1; s1_valid = 1; s1_x = 77; s1_y = 33; s1_colour = 9; s1_last = 0;
        cyc();
        frame_update = 0; s1_valid = 0;
        @(negedge clk);
        n_checks += 3;
        if (s0_ready !== 1 || s1_ready !== 0) begin
            n_fail++; $display("FAIL abort_state: got s0r%0b s1r%0b want s0r1 s1r0", s0_ready, s1_ready);
        end
        if (m_valid !== 1) begin n_fail++; $display("FAIL abort_fwd_valid: got %0b want 1", m_valid); end
        if (m_x !== 10'd77 || m_y !== 10'd33 || m_colour !== 4'd9) begin
            n_fail++; $display("FAIL abort_fwd_pixel: got (%0d,%0d,%0d) want (77,33,9)", m_x, m_y, m_colour);
        end
        n = 0;
        while (s0_ready === 1 && n < 100) begin n++; @(negedge clk); end
        n_checks++;
        if (n !== TO) begin n_fail++; $display("FAIL abort_wd_cleared: got %0d want %0d", n, TO); end
`ifdef FB_WR_STATS_EN
        n_checks++;
        if (overrun_count !== 8'd2) begin n_fail++; $display("FAIL abort_overrun: got %0d want 2", overrun_count); end
`endif
        @(posedge clk); #1;
        s1_valid = 1; s1_last = 1; s1_x = 12; s1_y = 13; frame_update = 1;
        cyc();
        s1_valid = 0; frame_update = 0;
        @(negedge clk);
        n_checks += 2;
        if (frame_done !== 0) begin n_fail++; $display("FAIL restart_wins_done: got %0b want 0", frame_done); end
        if (s0_ready !== 1 || m_valid !== 1) begin
            n_fail++; $display("FAIL restart_wins_state: got s0r%0b mv%0b want 1 1", s0_ready, m_valid);
        end
        @(posedge clk); #1;
        s0_valid = 1; s0_last = 0; s0_x = 100; s0_y = 100; s0_colour = 2;
        cyc();
        s0_valid = 0;
        rst = 1;
        #1;
        n_checks += 3;
        if (m_valid !== 0 || m_x !== 0 || m_y !== 0 || m_colour !== 0) begin
            n_fail++; $display("FAIL async_rst_m: got v%0b (%0d,%0d,%0d) want all 0", m_valid, m_x, m_y, m_colour);
        end
        if (s0_ready !== 0 || s1_ready !== 0 || busy !== 0) begin
            n_fail++; $display("FAIL async_rst_state: got s0r%0b s1r%0b busy%0b want 0", s0_ready, s1_ready, busy);
        end
        if (frame_done !== 0) begin n_fail++; $display("FAIL async_rst_done: got %0b want 0", frame_done); end
        cyc();
        rst = 0;
        cyc();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_basic();
        test_no_overlay();
        test_clip();
        test_watchdog();
        test_abort();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish before 2000000");
        $fatal(1, "bench timed out");
    end

endmodule
